// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide producing HI/LO; 33-cycle latency, busy while not IDLE.
// Define MULDIV_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise ops 1xx are rejected.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        write_hi,
  output logic        write_lo,
  output logic [31:0] dest_hi_data,
  output logic [31:0] dest_lo_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] mag_a, mag_b;
  logic [31:0] work_hi, work_lo;
  logic [31:0] last_hi, last_lo;
  logic [63:0] acc_q;

  logic op_legal, accept;
`ifdef MULDIV_ACCUM_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~op[2];
`endif
  assign accept = start & ~flush & op_legal;

  // op[0] clear selects the signed form of every operation
  logic        in_signed, in_div;
  logic [31:0] in_mag_a, in_mag_b;
  assign in_signed = ~op[0];
  assign in_div    = ~op[2] & op[1];
  assign in_mag_a  = (in_signed && a[31]) ? -a : a;
  assign in_mag_b  = (in_signed && b[31]) ? -b : b;

  logic q_signed, q_div;
  assign q_signed = ~op_q[0];
  assign q_div    = ~op_q[2] & op_q[1];

  // Multiply step: conditional add into HI, then shift {carry,HI,LO} right.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_a} : 33'd0);
  assign mul_hi  = mul_sum[32:1];
  assign mul_lo  = {mul_sum[0], work_lo[31:1]};

  // Restoring divide step: HI holds the partial remainder, LO shifts dividend out and quotient in.
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] div_hi, div_lo;
  assign div_shift = {work_hi, work_lo[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
  assign div_ge    = ~div_diff[33];
  assign div_hi    = div_ge ? div_diff[31:0] : div_shift[31:0];
  assign div_lo    = {work_lo[30:0], div_ge};

  logic [63:0] prod_mag, prod_s, mul_res;
  logic        res_neg;
  assign prod_mag = {mul_hi, mul_lo};
  assign res_neg  = q_signed & (a_q[31] ^ b_q[31]);
  assign prod_s   = res_neg ? -prod_mag : prod_mag;
`ifdef MULDIV_ACCUM_EN
  assign mul_res  = ~op_q[2] ? prod_s : (op_q[1] ? acc_q - prod_s : acc_q + prod_s);
`else
  assign mul_res  = prod_s;
`endif

  logic [31:0] quo, rem;
  logic [63:0] fin;
  assign quo = res_neg ? -div_lo : div_lo;
  assign rem = (q_signed && a_q[31]) ? -div_hi : div_hi;

  always_comb begin
    fin = mul_res;
    if (q_div) begin
      if (b_q == 32'd0) fin = {a_q, 32'hFFFF_FFFF};
      else              fin = {rem, quo};
    end
  end

  logic unused_bits;
`ifdef MULDIV_ACCUM_EN
  assign unused_bits = ^{div_diff[32], div_shift[32]};
`else
  assign unused_bits = ^{div_diff[32], div_shift[32], acc_q};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        if (flush)             state_nxt = ST_IDLE;
        else if (cnt == 5'd31) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result is only presented in an unflushed DONE cycle; otherwise the last committed value is held.
  always_comb begin
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE) & ~flush;
    write_hi     = done;
    write_lo     = done;
    dest_hi_data = done ? work_hi : last_hi;
    dest_lo_data = done ? work_lo : last_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 5'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      mag_a   <= 32'd0;
      mag_b   <= 32'd0;
      acc_q   <= 64'd0;
      work_hi <= 32'd0;
      work_lo <= 32'd0;
      last_hi <= 32'd0;
      last_lo <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt     <= 5'd0;
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            mag_a   <= in_mag_a;
            mag_b   <= in_mag_b;
            acc_q   <= {hi_in, lo_in};
            work_hi <= 32'd0;
            work_lo <= in_div ? in_mag_a : in_mag_b;
          end
        end
        ST_CALC: begin
          if (!flush) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              work_hi <= fin[63:32];
              work_lo <= fin[31:0];
            end else if (q_div) begin
              work_hi <= div_hi;
              work_lo <= div_lo;
            end else begin
              work_hi <= mul_hi;
              work_lo <= mul_lo;
            end
          end
        end
        ST_DONE: begin
          if (!flush) begin
            last_hi <= work_hi;
            last_lo <= work_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, multi-cycle corner sequences and random ops
// checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, hi_in, lo_in;
  logic        busy, done, write_hi, write_lo;
  logic [31:0] dest_hi_data, dest_lo_data;

  int total = 0;
  int bad = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

`ifdef MULDIV_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .busy(busy), .done(done),
    .write_hi(write_hi), .write_lo(write_lo),
    .dest_hi_data(dest_hi_data), .dest_lo_data(dest_lo_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {HI, LO}.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] va, vb, vh, vl);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p, acc;
    sa  = $signed(va);
    sb  = $signed(vb);
    ua  = {32'd0, va};
    ub  = {32'd0, vb};
    acc = {vh, vl};
    p   = o[0] ? ua * ub : sa * sb;
    case (o)
      3'b010: begin
        if (vb == 32'd0) return {va, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'b011: begin
        if (vb == 32'd0) return {va, 32'hFFFF_FFFF};
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
      3'b100, 3'b101: return acc + p;
      3'b110, 3'b111: return acc - p;
      default: return p;
    endcase
  endfunction

  // Drives one request and checks busy/done profile and data over cycles N+1..N+34.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va, vb, vh, vl,
                        input logic [63:0] exp, input bit acc_ok, input int reassert_at);
    int busy_err = 0;
    int pulse_err = 0;
    op = o; a = va; b = vb; hi_in = vh; lo_in = vl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; hi_in = $urandom; lo_in = $urandom;
    op = 3'($urandom_range(0, 7));
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (busy !== (acc_ok && k <= 33)) busy_err++;
      if ({done, write_hi, write_lo} !== ((acc_ok && k == 33) ? 3'b111 : 3'b000)) pulse_err++;
      if (k == 33) check({name, "/data"}, {dest_hi_data, dest_lo_data}, exp);
      if (k == reassert_at) begin
        start = 1'b1; op = 3'b001; a = $urandom; b = $urandom;
      end else if (k == reassert_at + 1) begin
        start = 1'b0;
      end
    end
    check({name, "/busy_profile_errs"}, 64'(busy_err), 64'd0);
    check({name, "/pulse_profile_errs"}, 64'(pulse_err), 64'd0);
    check({name, "/held"}, {dest_hi_data, dest_lo_data}, exp);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int err;
    logic [2:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    bit          ok;
    logic [63:0] rexp;

    tbl[0] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[1] = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[2] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[3] = '{3'b011, 32'h0000_000A, 32'h0000_0000, 64'h0000_000A_FFFF_FFFF};
    tbl[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    tbl[5] = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    tbl[6] = '{3'b010, 32'hFFFF_FFF8, 32'h0000_0000, 64'hFFFF_FFF8_FFFF_FFFF};
    tbl[7] = '{3'b011, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E};
    tbl[8] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    tbl[9] = '{3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0;
    a = 32'd0; b = 32'd0; hi_in = 32'd0; lo_in = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_pulse", 64'({done, write_hi, write_lo}), 64'd0);
    check("reset_data", {dest_hi_data, dest_lo_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, $urandom, $urandom,
             tbl[i].exp, 1'b1, 0);

    // re-request while busy must be ignored
    run_op("reassert", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0,
           64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 5);

`ifdef MULDIV_ACCUM_EN
    run_op("maddu", 3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000, 1'b1, 0);
`else
    run_op("maddu_rejected", 3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, {last_hi, last_lo}, 1'b0, 0);
`endif

    // flush in CALC at N+10, then a new MULTU at N+11
    err = 0;
    op = 3'b011; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done | write_hi | write_lo | ~busy) err++;
      if (k == 10) flush = 1'b1;
    end
    @(posedge clk); #1;
    flush = 1'b0; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    check("flush_calc_busy", 64'(busy), 64'd0);
    check("flush_calc_held", {dest_hi_data, dest_lo_data}, {last_hi, last_lo});
    if (done | write_hi | write_lo) err++;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 12; k <= 44; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) err++;
      if ({done, write_hi, write_lo} !== ((k == 44) ? 3'b111 : 3'b000)) err++;
      if (k == 44) check("flush_then_multu_data", {dest_hi_data, dest_lo_data}, 64'hFFFF_FFFE_0000_0001);
    end
    @(negedge clk);
    check("flush_then_multu_idle", 64'(busy), 64'd0);
    check("flush_calc_profile_errs", 64'(err), 64'd0);
    last_hi = 32'hFFFF_FFFE; last_lo = 32'h0000_0001;

    // flush in DONE suppresses the write and the held value stays
    op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (33) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done_pulse", 64'({done, write_hi, write_lo}), 64'd0);
    check("flush_done_data", {dest_hi_data, dest_lo_data}, {last_hi, last_lo});
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 64'(busy), 64'd0);
    check("flush_done_held", {dest_hi_data, dest_lo_data}, {last_hi, last_lo});

    // start and flush together in IDLE: not accepted
    err = 0;
    op = 3'b001; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (busy | done | write_hi | write_lo) err++;
    end
    check("start_flush_same_cycle", 64'(err), 64'd0);

    // reset mid-CALC aborts and clears outputs
    err = 0;
    op = 3'b001; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("reset_calc_busy", 64'(busy), 64'd0);
    check("reset_calc_data", {dest_hi_data, dest_lo_data}, 64'd0);
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (busy | done | write_hi | write_lo) err++;
    end
    check("reset_calc_no_write", 64'(err), 64'd0);
    last_hi = 32'd0; last_lo = 32'd0;

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      rh = $urandom;
      rl = $urandom;
      ok = (ro[2] == 1'b0) || ACC;
      rexp = ok ? ref_model(ro, ra, rb, rh, rl) : {last_hi, last_lo};
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rh, rl, rexp, ok, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  request a new operation (sampled only in IDLE).
REQ-004 SHALL have ports: op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-005 SHALL have ports: a, b  in  32 each  rs/rt operands; a = dividend, b = divisor.
REQ-006 SHALL have ports: hi_in, lo_in  in  32 each  current HI/LO (forwarded) for accumulate ops.
REQ-007 SHALL have ports: flush  in  1  kill the in-flight operation (exception/nullify).
REQ-008 SHALL have ports: busy  out  1  high whenever state is not IDLE; decode stalls HI/LO readers and new muldiv ops on it.
REQ-009 SHALL have ports: done  out  1  one-cycle result pulse.
REQ-010 SHALL have ports: write_hi, write_lo  out  1 each  HI/LO register write enables toward the decode-stage HI/LO registers.
REQ-011 SHALL have ports: dest_hi_data, dest_lo_data  out  32 each  result written to HI/LO.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE, busy = (state != IDLE).
REQ-013 IDLE: start & !flush & legal op SHALL latch a, b, op, hi_in, lo_in, clear 5-bit counter, go CALC; start while busy SHALL be ignored.
REQ-014 CALC SHALL perform one radix-2 step per cycle for 32 cycles (counter 0..31), moving to DONE after counter = 31.
REQ-015 Latency: start accepted in cycle N -> busy high N+1..N+33; done, write_hi, write_lo high in cycle N+33 only.
REQ-016 done, write_hi, write_lo SHALL be 0 outside DONE; dest_*_data SHALL hold last result between operations.
REQ-017 MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product; signed via operand magnitude and final negate.
REQ-018 DIV/DIVU: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-019 Divide by zero: HI = a, LO = 0xFFFFFFFF, still 33-cycle latency.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-021 flush in CALC SHALL return to IDLE next cycle with no write; flush in DONE SHALL suppress done/write_* that cycle and still return to IDLE.
REQ-022 start and flush in the same IDLE cycle: flush wins, operation not accepted.

Reset
REQ-023 reset SHALL force IDLE, counter 0, busy 0, done 0, write_hi 0, write_lo 0, dest_hi_data 0, dest_lo_data 0, all internal operand/accumulator registers 0.
REQ-024 reset during CALC or DONE SHALL abort with no write in the following cycle.

Configuration
REQ-025 Macro MULDIV_ACCUM_EN defined: ops 1xx legal; {HI,LO} = {hi_in,lo_in} +/- 64-bit product (MADD/MSUB signed, MADDU/MSUBU unsigned), wrap mod 2^64, same latency.
REQ-026 MULDIV_ACCUM_EN undefined: ops 1xx SHALL not be accepted (busy stays 0, no write); hi_in/lo_in ports remain present and unused.

Verification
REQ-027 MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start cycle N -> cycle N+33 done=1, HI=0xFFFFFFFE, LO=0x00000001.
REQ-028 MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy=1 exactly N+1..N+33.
REQ-029 DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=10 b=0 -> HI=0x0000000A, LO=0xFFFFFFFF.
REQ-030 DIVU start N, flush at N+10 -> busy=0 at N+11, no write ever; new MULTU start at N+11 accepted, done at N+44.
REQ-031 start re-asserted at N+5 with different operands -> ignored, original result delivered at N+33.
REQ-032 MULDIV_ACCUM_EN: MADDU hi_in=0 lo_in=0xFFFFFFFF a=1 b=1 -> HI=1, LO=0; undefined: same stimulus -> busy stays 0, no write.
